// File: rtl/dma_axi_wr.sv
// Single-burst-outstanding AXI4 write master fed by a first-word-fall-through source.
// Optional 4 KB burst splitting is enabled by defining DMA_WR_4K_SPLIT_EN.
module dma_axi_wr #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int BURST_LEN      = 64
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]     dma_waddr,
    input  logic                          dma_wareq,
    input  logic [15:0]                   dma_wsize,
    output logic                          dma_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0]     dma_wdata,
    input  logic                          dma_wready,
    output logic                          dma_wvalid,
    output logic                          wr_err,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);
    // state  | meaning
    // S_IDLE | waiting for a non-empty request
    // S_ADDR | presenting AW for the current burst
    // S_DATA | streaming beats from the source
    // S_RESP | waiting for the burst's write response
    localparam int BPB     = AXI_DATA_WIDTH / 8;
    localparam int SZ_LOG2 = $clog2(BPB);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [15:0]                 r_remain;
    logic [8:0]                  r_beats;
    logic [8:0]                  r_cnt;
    logic [7:0]                  r_awlen;
    logic                        r_busy;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_beat;
    logic                        w_b_done;
    logic                        w_next_burst;
    logic [AXI_ADDR_WIDTH-1:0]   w_step;
    logic [AXI_ADDR_WIDTH-1:0]   w_calc_addr;
    logic [15:0]                 w_calc_remain;
    logic [8:0]                  w_beats_len;
    logic [8:0]                  w_beats;

    assign w_accept     = (r_state == S_IDLE) && dma_wareq && (dma_wsize != 16'd0);
    assign w_beat       = (r_state == S_DATA) && dma_wready && M_AXI_WREADY;
    assign w_b_done     = (r_state == S_RESP) && M_AXI_BVALID;
    assign w_next_burst = w_b_done && (r_remain != 16'd0);

    // Next burst starts where the previous one ended; first burst takes the request.
    assign w_step        = AXI_ADDR_WIDTH'(r_beats) << SZ_LOG2;
    assign w_calc_addr   = (r_state == S_IDLE) ? dma_waddr : r_addr + w_step;
    assign w_calc_remain = (r_state == S_IDLE) ? dma_wsize : r_remain;
    assign w_beats_len   = (w_calc_remain > 16'(BURST_LEN)) ? 9'(BURST_LEN) : w_calc_remain[8:0];

`ifdef DMA_WR_4K_SPLIT_EN
    logic [12:0] w_4k_bytes;
    logic [12:0] w_4k_beats;
    assign w_4k_bytes = 13'd4096 - {1'b0, w_calc_addr[11:0]};
    assign w_4k_beats = w_4k_bytes >> SZ_LOG2;
    assign w_beats    = ({4'd0, w_beats_len} > w_4k_beats) ? w_4k_beats[8:0] : w_beats_len;
`else
    assign w_beats    = w_beats_len;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_ADDR;
            S_ADDR: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                M_AXI_WVALID = dma_wready;
                if (w_beat && (r_cnt == 9'd1)) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) w_state_nxt = (r_remain != 16'd0) ? S_ADDR : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_beats  <= '0;
            r_cnt    <= '0;
            r_awlen  <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept || w_next_burst) begin
                r_addr   <= w_calc_addr;
                r_awlen  <= 8'(w_beats - 9'd1);
                r_beats  <= w_beats;
                r_cnt    <= w_beats;
                r_remain <= w_calc_remain - 16'(w_beats);
            end else if (w_beat) begin
                r_cnt <= r_cnt - 9'd1;
            end
            if (w_accept)                              r_busy <= 1'b1;
            else if (w_b_done && r_remain == 16'd0)    r_busy <= 1'b0;
            if (w_accept)                              r_err  <= 1'b0;
            else if (w_b_done && M_AXI_BRESP != 2'b00) r_err  <= 1'b1;
        end
    end

    assign dma_wbusy     = r_busy;
    assign dma_wvalid    = w_beat;
    assign wr_err        = r_err;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWLEN   = r_awlen;
    assign M_AXI_AWSIZE  = 3'(SZ_LOG2);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = dma_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (r_state == S_DATA) && (r_cnt == 9'd1);
endmodule
